// File: rtl/fnd_pkg.sv
// Shared constants, digit-index type and binary-to-BCD helper for the FND scan driver.
// Segment codes are active-low {g..a}; the decimal point is added by the decoder.
package fnd_pkg;

  localparam int IDX_W = 2;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] COM_OFF = 4'hF;

  typedef enum logic [IDX_W-1:0] {
    DIG_RES_ONES = 2'd0,
    DIG_RES_TENS = 2'd1,
    DIG_A_ONES   = 2'd2,
    DIG_A_TENS   = 2'd3
  } dig_idx_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Inputs never exceed 31, so a three-step compare/subtract covers every case.
  function automatic bcd_t bin2bcd(input logic [4:0] v);
    bcd_t r;
    if (v >= 5'd30) begin
      r.tens = 4'd3;
      r.ones = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      r.tens = 4'd2;
      r.ones = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      r.tens = 4'd1;
      r.ones = 4'(v - 5'd10);
    end else begin
      r.tens = 4'd0;
      r.ones = v[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fnd_digit_decoder.sv
// Combinational BCD to active-low seven-segment decoder; dp is always off.
// Non-decimal codes and an asserted blank both turn every segment off.
module fnd_digit_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  logic [6:0] seg7;

  always_comb begin
    seg7 = SEG_BLANK;
    case (i_bcd)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
    o_seg = i_blank ? SEG_OFF : {1'b1, seg7};
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Latches operand A and adder result, scans them in decimal over a 4-digit common-anode FND.
// Outputs are registered; every digit change inserts one all-off cycle against ghosting.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int CLK_DIV  = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [3:0] i_a,
  input  logic [3:0] i_sum,
  input  logic       i_carry,
  output logic [7:0] o_seg,
  output logic [3:0] o_com
);

  localparam int            PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [3:0]    a_q, a_d;
  logic [4:0]    res_q, res_d;
  logic [PW-1:0] presc_q, presc_d;
  dig_idx_t      idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    com_q, com_d;

  bcd_t       a_bcd, res_bcd;
  logic [3:0] dig_bcd;
  logic       dig_blank;
  logic [7:0] dig_seg;
  logic       wrap;

  fnd_digit_decoder u_dec (
    .i_bcd   (dig_bcd),
    .i_blank (dig_blank),
    .o_seg   (dig_seg)
  );

  always_comb begin
    a_bcd   = bin2bcd({1'b0, a_q});
    res_bcd = bin2bcd(res_q);
    wrap    = (presc_q == PRESC_MAX);

    a_d   = a_q;
    res_d = res_q;
    if (i_valid) begin
      a_d   = i_a;
      res_d = {i_carry, i_sum};
    end

    presc_d = wrap ? '0 : presc_q + PW'(1);
    idx_d   = wrap ? dig_idx_t'(IDX_W'(idx_q) + IDX_W'(1)) : idx_q;

    dig_bcd   = res_bcd.ones;
    dig_blank = 1'b0;
    case (idx_q)
      DIG_RES_ONES: dig_bcd = res_bcd.ones;
      DIG_RES_TENS: begin
        dig_bcd   = res_bcd.tens;
        dig_blank = (BLANK_LZ != 0) && (res_bcd.tens == 4'd0);
      end
      DIG_A_ONES:   dig_bcd = a_bcd.ones;
      DIG_A_TENS: begin
        dig_bcd   = a_bcd.tens;
        dig_blank = (BLANK_LZ != 0) && (a_bcd.tens == 4'd0);
      end
      default:      dig_bcd = res_bcd.ones;
    endcase

    // The advancing edge shows nothing, so the old digit's pattern never lights the new anode.
    com_d = wrap ? COM_OFF : ~(4'b0001 << idx_q);
    seg_d = wrap ? SEG_OFF : dig_seg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      res_q   <= '0;
      presc_q <= '0;
      idx_q   <= DIG_RES_ONES;
      seg_q   <= SEG_OFF;
      com_q   <= COM_OFF;
    end else begin
      a_q     <= a_d;
      res_q   <= res_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
    end
  end

  assign o_seg = seg_q;
  assign o_com = com_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: directed scan/decimal checks plus random captures against a slot-arithmetic model.
// Two instances share stimulus, one with leading-zero blanking and one without.
module tb_fnd_scan_driver;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [3:0] i_a = 4'd0;
  logic [3:0] i_sum = 4'd0;
  logic       i_carry = 1'b0;
  logic [7:0] seg1, seg0;
  logic [3:0] com1, com0;

  int n_tests = 0;
  int n_fail  = 0;

  int k = 0;
  int lat_a = 0;
  int lat_r = 0;
  logic [7:0] e_seg1 = 8'hFF;
  logic [7:0] e_seg0 = 8'hFF;
  logic [3:0] e_com  = 4'hF;
  bit run_chk = 1'b0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  fnd_scan_driver #(.CLK_DIV(D), .BLANK_LZ(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_a(i_a),
    .i_sum(i_sum), .i_carry(i_carry), .o_seg(seg1), .o_com(com1)
  );

  fnd_scan_driver #(.CLK_DIV(D), .BLANK_LZ(0)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_a(i_a),
    .i_sum(i_sum), .i_carry(i_carry), .o_seg(seg0), .o_com(com0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  // Output after edge k: edge k is a digit change when k is a multiple of D; otherwise
  // the digit shown is (k / D) mod 4, using values latched before edge k.
  function automatic logic [7:0] exp_seg(input int kk, input int a, input int r, input bit blz);
    int idx, v, dig;
    if (kk % D == 0) return 8'hFF;
    idx = (kk / D) % 4;
    v   = (idx < 2) ? r : a;
    dig = (idx % 2 == 1) ? v / 10 : v % 10;
    if (blz && (idx % 2 == 1) && dig == 0) return 8'hFF;
    return seg_tab[dig];
  endfunction

  function automatic logic [3:0] exp_com(input int kk);
    if (kk % D == 0) return 4'hF;
    return ~(4'b0001 << ((kk / D) % 4));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      lat_a = 0;
      lat_r = 0;
      e_seg1 = 8'hFF;
      e_seg0 = 8'hFF;
      e_com  = 4'hF;
    end else begin
      k++;
      e_seg1 = exp_seg(k, lat_a, lat_r, 1'b1);
      e_seg0 = exp_seg(k, lat_a, lat_r, 1'b0);
      e_com  = exp_com(k);
      if (i_valid) begin
        lat_a = int'(i_a);
        lat_r = int'({i_carry, i_sum});
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      if (!rst_n) begin
        chk("rst_seg", seg1, 8'hFF);
        chk("rst_com", {4'h0, com1}, 8'h0F);
      end else begin
        chk("scan_seg", seg1, e_seg1);
        chk("scan_seg_nolz", seg0, e_seg0);
        chk("scan_com", {4'h0, com1}, {4'h0, e_com});
        chk("scan_com_nolz", {4'h0, com0}, {4'h0, e_com});
      end
    end
  end

  task automatic capture(input int a, input int r);
    i_valid = 1'b1;
    i_a     = 4'(a);
    i_sum   = 4'(r);
    i_carry = r[4];
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic goto_slot(input int idx);
    bit hit = 1'b0;
    for (int n = 0; n < 8 * D && !hit; n++) begin
      @(negedge clk);
      hit = (k % D != 0) && ((k / D) % 4 == idx);
    end
    chk("slot_reached", {7'd0, hit}, 8'd1);
  endtask

  task automatic goto_phase(input int p);
    bit hit = 1'b0;
    for (int n = 0; n < 2 * D && !hit; n++) begin
      @(negedge clk);
      hit = (k % D == p);
    end
    chk("phase_reached", {7'd0, hit}, 8'd1);
  endtask

  task automatic goto_edge(input int e);
    bit hit = (k == e);
    for (int n = 0; n < 64 && !hit; n++) begin
      @(negedge clk);
      hit = (k == e);
    end
    chk("edge_reached", {7'd0, hit}, 8'd1);
  endtask

  int         rs      [5] = '{10, 19, 20, 30, 31};
  logic [7:0] tens_e  [5] = '{8'hF9, 8'hF9, 8'hA4, 8'hB0, 8'hB0};
  logic [7:0] ones_e  [5] = '{8'hC0, 8'h90, 8'hC0, 8'hC0, 8'hF9};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    // Reset state and the idle scan sequence.
    repeat (3) @(negedge clk);
    chk("reset_seg", seg1, 8'hFF);
    chk("reset_com", {4'h0, com1}, 8'h0F);
    run_chk = 1'b1;
    rst_n = 1'b1;
    goto_edge(1);
    chk("first_com", {4'h0, com1}, 8'h0E);
    chk("first_seg", seg1, 8'hC0);
    goto_edge(4);
    chk("blank1_com", {4'h0, com1}, 8'h0F);
    goto_edge(5);
    chk("idx1_com", {4'h0, com1}, 8'h0D);
    chk("idx1_lz", seg1, 8'hFF);
    chk("idx1_nolz", seg0, 8'hC0);
    goto_edge(9);
    chk("idx2_com", {4'h0, com1}, 8'h0B);
    chk("idx2_seg", seg1, 8'hC0);
    goto_edge(13);
    chk("idx3_com", {4'h0, com1}, 8'h07);
    chk("idx3_lz", seg1, 8'hFF);

    // A=13, result 27.
    capture(13, 27);
    goto_slot(0); chk("r27_ones", seg1, 8'hF8);
    goto_slot(1); chk("r27_tens", seg1, 8'hA4);
    goto_slot(2); chk("a13_ones", seg1, 8'hB0);
    goto_slot(3); chk("a13_tens", seg1, 8'hF9);

    // Leading-zero blanking on and off.
    capture(0, 9);
    goto_slot(0); chk("r9_ones", seg1, 8'h90); chk("r9_ones_nolz", seg0, 8'h90);
    goto_slot(1); chk("r9_tens_lz", seg1, 8'hFF); chk("r9_tens_nolz", seg0, 8'hC0);
    goto_slot(3); chk("a0_tens_lz", seg1, 8'hFF); chk("a0_tens_nolz", seg0, 8'hC0);

    // Back-to-back strobes: last one wins.
    i_valid = 1'b1; i_a = 4'd2; i_sum = 4'd5; i_carry = 1'b0;
    @(negedge clk);
    i_a = 4'd3; i_sum = 4'd15; i_carry = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    goto_slot(1); chk("b2b_tens", seg1, 8'hB0);
    goto_slot(0); chk("b2b_ones", seg1, 8'hF9);

    // Strobe on the digit-advance edge.
    goto_phase(D - 1);
    capture(9, 22);
    chk("wrapcap_com", {4'h0, com1}, 8'h0F);
    chk("wrapcap_seg", seg1, 8'hFF);
    @(negedge clk);
    chk("wrapcap_next_seg", seg1, exp_seg(k, 9, 22, 1'b1));
    chk("wrapcap_next_com", {4'h0, com1}, {4'h0, exp_com(k)});

    // Asynchronous reset in the middle of the idx2 slot.
    goto_slot(2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", seg1, 8'hFF);
    chk("async_rst_com", {4'h0, com1}, 8'h0F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto_edge(1);
    chk("rerst_com", {4'h0, com1}, 8'h0E);
    chk("rerst_seg", seg1, 8'hC0);
    goto_edge(4);
    chk("rerst_blank", {4'h0, com1}, 8'h0F);
    goto_edge(9);
    chk("rerst_idx2_com", {4'h0, com1}, 8'h0B);
    chk("rerst_a_zero", seg1, 8'hC0);

    // Binary-to-BCD boundaries.
    for (int i = 0; i < 5; i++) begin
      capture(int'($urandom_range(0, 15)), rs[i]);
      goto_slot(1); chk("bcd_tens", seg1, tens_e[i]);
      goto_slot(0); chk("bcd_ones", seg1, ones_e[i]);
    end

    // Random captures; inputs also wiggle while the strobe is low.
    for (int n = 0; n < 1500; n++) begin
      i_valid = ($urandom_range(0, 7) == 0);
      i_a     = 4'($urandom_range(0, 15));
      i_sum   = 4'($urandom_range(0, 15));
      i_carry = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    i_valid = 1'b0;
    repeat (4 * D) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
